// File: rtl/m2_serial_adder_if.sv
// ---------------------------------------------------------------------------
// m2_serial_adder_if
//   Handshake and data bundle for the bit-serial adder.
//
//   Input side  : in_valid_i / in_ready_o handshake carrying a_i, b_i, cin_i.
//   Output side : out_valid_o / out_ready_i handshake carrying sum_o, cout_o
//                 (and ovf_o when SERIAL_ADDER_OVF_EN is defined).
//   Status      : busy_o is high while the adder is stepping through bits.
//
//   The signal suffixes are written from the adder's point of view.
//   master modport : the producer/consumer side that drives operands and
//                    takes results.
//   slave modport  : the adder itself.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf_o signal.
// ---------------------------------------------------------------------------
interface m2_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             busy_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_o;
`endif

  modport master (
    output in_valid_i, a_i, b_i, cin_i, out_ready_i,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf_o,
`endif
    input  in_ready_o, out_valid_o, sum_o, cout_o, busy_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, out_ready_i,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf_o,
`endif
    output in_ready_o, out_valid_o, sum_o, cout_o, busy_o
  );
endinterface

// File: rtl/m2_serial_adder.sv
// ---------------------------------------------------------------------------
// m2_serial_adder
//   Bit-serial WIDTH-bit adder. One full-adder cell plus a carry flop is
//   reused over WIDTH clocks, LSB first, instead of a ripple chain.
//
//   Ports:
//     clk_i   rising-edge clock
//     rst_ni  asynchronous active-low reset
//     bus     m2_serial_adder_if.slave
//               in_valid_i/in_ready_o, a_i, b_i, cin_i   operand handshake
//               out_valid_o/out_ready_i, sum_o, cout_o   result handshake
//               busy_o                                    high while running
//               ovf_o                                     signed overflow
//                                                        (SERIAL_ADDER_OVF_EN)
//
//   Parameter WIDTH: operand width, 2..32.
//   Optional feature macro: SERIAL_ADDER_OVF_EN enables ovf_o.
//
//   Flow: IDLE accepts operands, RUN consumes one bit per edge for WIDTH
//   edges, DONE holds the result until the consumer takes it. All outputs
//   come straight from registers.
// ---------------------------------------------------------------------------
module m2_serial_adder #(
  parameter int WIDTH = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  m2_serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-adder cell working on the current LSBs.
  logic bit_sum;
  logic bit_carry;
  logic last_bit;

  assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          carry_d = bus.cin_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB.
        sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_carry;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB step carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ bit_carry;
`endif
        end
      end

      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.busy_o      = (state_q == RUN);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.sum_o       = sum_q;
  // After the final step the carry flop holds the carry out of the MSB.
  assign bus.cout_o      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_m2_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_m2_serial_adder
//   Directed bench for m2_serial_adder at WIDTH=8. A transaction-level model
//   tracks what the block must present; a compare process checks it every
//   falling edge, and directed tasks pin literal results and timing.
// ---------------------------------------------------------------------------
module tb_m2_serial_adder;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m2_serial_adder_if #(.WIDTH(W)) bus ();

  m2_serial_adder #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction model: an accepted op produces A+B+cin exactly W edges
  // later and holds it until the consumer handshakes.
  // ------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t         m_ph   = M_IDLE;
  int           m_left = 0;
  logic [W:0]   m_full = '0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= M_IDLE;
      m_left <= 0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      case (m_ph)
        M_IDLE: if (bus.in_valid_i) begin
          m_ph   <= M_RUN;
          m_left <= W;
          m_a    <= bus.a_i;
          m_b    <= bus.b_i;
          m_full <= {1'b0, bus.a_i} + {1'b0, bus.b_i} + {{W{1'b0}}, bus.cin_i};
        end
        M_RUN: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_ph   <= M_DONE;
            m_sum  <= m_full[W-1:0];
            m_cout <= m_full[W];
            m_ovf  <= (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
          end
        end
        M_DONE: if (bus.out_ready_i) m_ph <= M_IDLE;
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready_o),  32'(m_ph == M_IDLE));
    chk("busy",      32'(bus.busy_o),      32'(m_ph == M_RUN));
    chk("out_valid", 32'(bus.out_valid_o), 32'(m_ph == M_DONE));
    if (m_ph != M_RUN) begin
      chk("sum",  32'(bus.sum_o),  32'(m_sum));
      chk("cout", 32'(bus.cout_o), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf",  32'(bus.ovf_o),  32'(m_ovf));
`endif
    end
  end

  // ------------------------------------------------------------------
  // Directed stimulus
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, output int edges);
    edges = 0;
    while (!bus.out_valid_o && edges < 40) begin
      step();
      edges++;
    end
    if (!bus.out_valid_o) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic handshake();
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] es, input logic ec, input logic eo);
    int edges;
    int busy_n;
    bus.a_i        = a;
    bus.b_i        = b;
    bus.cin_i      = cin;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    busy_n = bus.busy_o ? 1 : 0;
    edges  = 0;
    while (!bus.out_valid_o && edges < 40) begin
      step();
      edges++;
      if (bus.busy_o) busy_n++;
    end
    chk("latency",     32'(edges),  32'd8);
    chk("busy_cycles", 32'(busy_n), 32'd8);
    chk("lit_sum",     32'(bus.sum_o),  32'(es));
    chk("lit_cout",    32'(bus.cout_o), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk("lit_ovf",     32'(bus.ovf_o),  32'(eo));
`else
    if (eo !== eo) chk("lit_ovf_x", 32'd0, 32'd1);
`endif
    $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d latency=%0d",
             a, b, cin, bus.sum_o, bus.cout_o, edges);
    handshake();
    chk("idle_after_hs", 32'(bus.in_ready_o), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int edges;
    int vcount;
    int prev_acc;
    int acc;
    int guard;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.cin_i       = 1'b0;
    bus.out_ready_i = 1'b0;
    rst_n           = 1'b0;
    repeat (3) step();

    // Reset state, with in_valid asserted to show nothing transfers.
    bus.in_valid_i = 1'b1;
    step();
    chk("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_busy",      32'(bus.busy_o),      32'd0);
    chk("rst_sum",       32'(bus.sum_o),       32'd0);
    chk("rst_cout",      32'(bus.cout_o),      32'd0);
    bus.in_valid_i = 1'b0;
    rst_n = 1'b1;
    step();

    // Literal vectors.
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o);

    // Backpressure with new operands offered during DONE.
    bus.a_i = 8'h0F; bus.b_i = 8'h01; bus.cin_i = 1'b0;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    wait_valid("bp", edges);
    bus.a_i = 8'h22; bus.b_i = 8'h11; bus.cin_i = 1'b0;
    bus.in_valid_i = 1'b1;
    repeat (5) begin
      step();
      chk("bp_valid",    32'(bus.out_valid_o), 32'd1);
      chk("bp_sum",      32'(bus.sum_o),       32'h10);
      chk("bp_cout",     32'(bus.cout_o),      32'd0);
      chk("bp_in_ready", 32'(bus.in_ready_o),  32'd0);
    end
    handshake();
    chk("bp_idle",  32'(bus.in_ready_o), 32'd1);
    chk("bp_nobusy", 32'(bus.busy_o),    32'd0);
    step();
    chk("bp_accept", 32'(bus.busy_o), 32'd1);
    bus.in_valid_i = 1'b0;
    wait_valid("bp2", edges);
    chk("bp2_sum", 32'(bus.sum_o), 32'h33);
    $display("op a=22 b=11 cin=0 after backpressure -> sum=%02h", bus.sum_o);
    handshake();

    // Reset in the middle of RUN.
    bus.a_i = 8'h12; bus.b_i = 8'h34; bus.cin_i = 1'b0;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(bus.out_valid_o), 32'd0);
    chk("mid_rst_busy",     32'(bus.busy_o),      32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready_o),  32'd1);
    chk("mid_rst_sum",      32'(bus.sum_o),       32'd0);
    chk("mid_rst_cout",     32'(bus.cout_o),      32'd0);
    step();
    step();
    rst_n = 1'b1;
    vcount = 0;
    repeat (12) begin
      step();
      if (bus.out_valid_o) vcount++;
    end
    chk("no_valid_after_rst", 32'(vcount), 32'd0);
    $display("op a=12 b=34 aborted by reset, valid pulses=%0d", vcount);
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Back-to-back stream with the consumer always ready.
    bus.out_ready_i = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus.a_i        = 8'($urandom);
      bus.b_i        = 8'($urandom);
      bus.cin_i      = 1'($urandom_range(0, 1));
      bus.in_valid_i = 1'b1;
      guard = 0;
      while (!bus.in_ready_o && guard < 40) begin
        step();
        guard++;
      end
      if (!bus.in_ready_o) chk("stream_timeout", 32'd0, 32'd1);
      step();
      acc = cycle;
      if (i > 0) chk("issue_interval", 32'(acc - prev_acc), 32'd10);
      $display("stream op %0d a=%02h b=%02h cin=%0d accepted at cycle %0d",
               i, bus.a_i, bus.b_i, bus.cin_i, acc);
      prev_acc = acc;
    end
    bus.in_valid_i = 1'b0;
    repeat (12) step();
    bus.out_ready_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
